// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: sequencer state encoding and the one-hot phase bus layout
// used by the decoder, register file, ALU and memory interface.
package cpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StF,
    StD,
    StE,
    StM,
    StW,
    StHalt
  } state_e;

  localparam int unsigned PHASE_W  = 5;

  localparam int unsigned PH_F_BIT = 0;
  localparam int unsigned PH_D_BIT = 1;
  localparam int unsigned PH_E_BIT = 2;
  localparam int unsigned PH_M_BIT = 3;
  localparam int unsigned PH_W_BIT = 4;

  localparam logic [PHASE_W-1:0] PH_F = 5'b00001;
  localparam logic [PHASE_W-1:0] PH_D = 5'b00010;
  localparam logic [PHASE_W-1:0] PH_E = 5'b00100;
  localparam logic [PHASE_W-1:0] PH_M = 5'b01000;
  localparam logic [PHASE_W-1:0] PH_W = 5'b10000;

  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    logic [PHASE_W-1:0] ph;
    ph = '0;
    case (s)
      StF:     ph = PH_F;
      StD:     ph = PH_D;
      StE:     ph = PH_E;
      StM:     ph = PH_M;
      StW:     ph = PH_W;
      default: ph = '0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/phase_wait_timer.sv
// Memory wait counter shared by the F and M phases; flags when MAX_WAIT stall cycles have
// accumulated since the last clear.
module phase_wait_timer #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] r_cnt;
  logic            w_at_max;

  assign w_at_max  = (r_cnt == CntW'(MAX_WAIT));
  assign o_timeout = w_at_max;

  // Saturates at MAX_WAIT; the owner leaves the stalling state before it matters.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle CPU phase sequencer: drives the one-hot F/D/E/M/W phase bus and owns the PC.
// Optional performance counters are enabled by defining PHASE_SEQUENCER_PERF_EN.
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_STEP  = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_imem_ready,
  input  logic               i_dmem_ready,
  input  logic               i_mem_op,
  input  logic               i_br_taken,
  input  logic [PC_W-1:0]    i_br_target,
  input  logic               i_halt_req,
  output logic [PHASE_W-1:0] o_phase,
  output logic [PC_W-1:0]    o_pc,
  output logic               o_retire,
  output logic               o_halted,
  output logic               o_bus_err
`ifdef PHASE_SEQUENCER_PERF_EN
  ,
  output logic [31:0]        o_cyc_cnt,
  output logic [31:0]        o_instret_cnt
`endif
);

  state_e             r_state;
  state_e             w_state_d;
  logic [PHASE_W-1:0] r_phase;
  logic [PC_W-1:0]    r_pc;
  logic               r_mem_op;
  logic               r_br_taken;
  logic [PC_W-1:0]    r_br_target;
  logic               r_halt;
  logic               r_bus_err;
  logic               w_timeout;
  logic               w_tmr_en;
  logic               w_tmr_clr;
  logic               w_err_set;

  phase_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // A ready seen on the timeout cycle is checked first, so it wins over the error.
  always_comb begin
    w_state_d = r_state;
    w_tmr_en  = 1'b0;
    w_err_set = 1'b0;
    case (r_state)
      StIdle: if (i_start) w_state_d = StF;
      StF: begin
        if (i_imem_ready) begin
          w_state_d = StD;
        end else if (w_timeout) begin
          w_state_d = StHalt;
          w_err_set = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      StD: w_state_d = StE;
      StE: w_state_d = StM;
      StM: begin
        if (!r_mem_op || i_dmem_ready) begin
          w_state_d = StW;
        end else if (w_timeout) begin
          w_state_d = StHalt;
          w_err_set = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      StW:     w_state_d = r_halt ? StHalt : StF;
      StHalt:  w_state_d = StHalt;
      default: w_state_d = StIdle;
    endcase
    w_tmr_clr = (w_state_d != r_state);
  end

  always_comb begin
    o_phase   = r_phase;
    o_pc      = r_pc;
    o_retire  = (r_state == StW);
    o_halted  = (r_state == StHalt);
    o_bus_err = r_bus_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase     <= '0;
      r_pc        <= PC_W'(RESET_PC);
      r_mem_op    <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_halt      <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_phase <= phase_of(w_state_d);
      if (r_state == StE) begin
        r_mem_op    <= i_mem_op;
        r_br_taken  <= i_br_taken;
        r_br_target <= i_br_target;
        r_halt      <= i_halt_req;
      end
      if (r_state == StW) begin
        r_pc <= r_br_taken ? r_br_target : r_pc + PC_W'(PC_STEP);
      end
      if (w_err_set) begin
        r_bus_err <= 1'b1;
      end
    end
  end

`ifdef PHASE_SEQUENCER_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_instret_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cyc_cnt     <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != StIdle && r_state != StHalt) begin
        r_cyc_cnt <= r_cyc_cnt + 32'd1;
      end
      if (r_state == StW) begin
        r_instret_cnt <= r_instret_cnt + 32'd1;
      end
    end
  end

  assign o_cyc_cnt     = r_cyc_cnt;
  assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus randomized stimulus,
// compared every cycle against an instruction-level model.
module tb_phase_sequencer;

  localparam int unsigned MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem;
  logic        dmem;
  logic        mem_op;
  logic        br;
  logic [15:0] tgt;
  logic        halt;
  logic [4:0]  phase;
  logic [15:0] pc;
  logic        retire;
  logic        halted;
  logic        bus_err;
`ifdef PHASE_SEQUENCER_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] instret_cnt;
`endif

  phase_sequencer #(
    .PC_W     (16),
    .RESET_PC (0),
    .PC_STEP  (4),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_imem_ready (imem),
    .i_dmem_ready (dmem),
    .i_mem_op     (mem_op),
    .i_br_taken   (br),
    .i_br_target  (tgt),
    .i_halt_req   (halt),
    .o_phase      (phase),
    .o_pc         (pc),
    .o_retire     (retire),
    .o_halted     (halted),
    .o_bus_err    (bus_err)
`ifdef PHASE_SEQUENCER_PERF_EN
    ,
    .o_cyc_cnt     (cyc_cnt),
    .o_instret_cnt (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Model: mode 0 idle, 1 running, 2 halted; pos is the instruction step 0..4 (F..W).
  int          m_mode = 0;
  int          m_pos = 0;
  int          m_wait = 0;
  logic [15:0] m_pc = 16'h0000;
  logic        m_err = 1'b0;
  logic        m_lmem = 1'b0;
  logic        m_lbr = 1'b0;
  logic [15:0] m_ltgt = 16'h0000;
  logic        m_lhalt = 1'b0;
  logic [31:0] m_cyc = 0;
  logic [31:0] m_inst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    if (rst) begin
      m_mode = 0; m_pos = 0; m_wait = 0; m_pc = 16'h0000; m_err = 1'b0;
      m_lmem = 1'b0; m_lbr = 1'b0; m_ltgt = 16'h0000; m_lhalt = 1'b0;
      m_cyc = 0; m_inst = 0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_pos = 0; m_wait = 0; end
    end else if (m_mode == 1) begin
      m_cyc = m_cyc + 1;
      case (m_pos)
        0: begin
          if (imem) begin m_pos = 1; m_wait = 0; end
          else if (m_wait == MAX_WAIT) begin m_mode = 2; m_err = 1'b1; end
          else m_wait++;
        end
        1: m_pos = 2;
        2: begin
          m_lmem = mem_op; m_lbr = br; m_ltgt = tgt; m_lhalt = halt;
          m_pos = 3; m_wait = 0;
        end
        3: begin
          if (!m_lmem || dmem) m_pos = 4;
          else if (m_wait == MAX_WAIT) begin m_mode = 2; m_err = 1'b1; end
          else m_wait++;
        end
        default: begin
          m_inst = m_inst + 1;
          m_pc = m_lbr ? m_ltgt : m_pc + 16'd4;
          if (m_lhalt) m_mode = 2;
          else begin m_pos = 0; m_wait = 0; end
        end
      endcase
    end
  endtask

  task automatic compare();
    logic [4:0] exp_ph;
    exp_ph = (m_mode == 1) ? 5'(1 << m_pos) : 5'd0;
    check("phase", 32'(phase), 32'(exp_ph));
    check("pc", 32'(pc), 32'(m_pc));
    check("retire", 32'(retire), 32'(m_mode == 1 && m_pos == 4));
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("bus_err", 32'(bus_err), 32'(m_err));
`ifdef PHASE_SEQUENCER_PERF_EN
    check("cyc_cnt", cyc_cnt, m_cyc);
    check("instret_cnt", instret_cnt, m_inst);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // One instruction starting in F with all memories ready; E-stage inputs applied on cycle 3.
  task automatic run_instr(input logic mop, input logic b, input logic [15:0] t, input logic h);
    imem = 1'b1; dmem = 1'b1;
    tick();
    tick();
    mem_op = mop; br = b; tgt = t; halt = h;
    tick();
    mem_op = 1'b0; br = 1'b0; halt = 1'b0;
    tick();
    tick();
  endtask

  task automatic go_to_m(input logic mop);
    start = 1'b1; tick(); start = 1'b0;
    imem = 1'b1; tick(); tick();
    mem_op = mop; tick(); mem_op = 1'b0;
  endtask

  initial begin
    int m_cycles;
    int retire_seen;
    rst = 1'b1; start = 1'b0; imem = 1'b1; dmem = 1'b1;
    mem_op = 1'b0; br = 1'b0; tgt = 16'h0000; halt = 1'b0;
    tick(); tick();
    check("reset_phase", 32'(phase), 32'h0);
    check("reset_pc", 32'(pc), 32'h0);
    rst = 1'b0;
    tick();
    check("idle_phase", 32'(phase), 32'h0);

    // Nominal 5-cycle instruction
    start = 1'b1; tick(); start = 1'b0;
    check("nom_f", 32'(phase), 32'h01);
    tick(); check("nom_d", 32'(phase), 32'h02);
    tick(); check("nom_e", 32'(phase), 32'h04);
    tick(); check("nom_m", 32'(phase), 32'h08);
    tick(); check("nom_w", 32'(phase), 32'h10);
    check("nom_retire", 32'(retire), 32'h1);
    tick(); check("nom_pc", 32'(pc), 32'h4);

    // F stretched by three not-ready cycles
    imem = 1'b0; tick(); tick(); tick();
    check("fstall_phase", 32'(phase), 32'h01);
    check("fstall_pc", 32'(pc), 32'h4);
    imem = 1'b1; tick();
    check("fstall_d", 32'(phase), 32'h02);
    tick();
    mem_op = 1'b1; tick(); mem_op = 1'b0;
    dmem = 1'b0; tick();
    check("mwait_phase", 32'(phase), 32'h08);
    dmem = 1'b1; tick();
    check("mwait_w", 32'(phase), 32'h10);
    tick();
    check("mwait_pc", 32'(pc), 32'h8);

    // No mem op: dmem_ready ignored
    tick(); tick();
    dmem = 1'b0; tick(); tick();
    check("nomem_w", 32'(phase), 32'h10);
    dmem = 1'b1; tick();
    check("nomem_pc", 32'(pc), 32'hC);

    run_instr(1'b0, 1'b1, 16'h0040, 1'b0);
    check("branch_pc", 32'(pc), 32'h0040);
    run_instr(1'b0, 1'b1, 16'hFFFC, 1'b0);
    check("branch_fffc", 32'(pc), 32'hFFFC);
    run_instr(1'b0, 1'b0, 16'h1234, 1'b0);
    check("wrap_pc", 32'(pc), 32'h0000);

    // Halt combined with taken branch, then start ignored
    run_instr(1'b0, 1'b1, 16'h0100, 1'b1);
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_phase", 32'(phase), 32'h0);
    check("halt_pc", 32'(pc), 32'h0100);
    start = 1'b1; tick(); tick(); tick(); start = 1'b0;
    check("halt_sticky", 32'(halted), 32'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);

    // Hung data memory times out
    go_to_m(1'b1);
    dmem = 1'b0; m_cycles = 0; retire_seen = 0;
    for (int k = 0; k < 40 && phase == 5'h08; k++) begin
      m_cycles++;
      tick();
      if (retire) retire_seen++;
    end
    check("to_mcycles", 32'(m_cycles), 32'd16);
    check("to_bus_err", 32'(bus_err), 32'h1);
    check("to_halted", 32'(halted), 32'h1);
    check("to_pc", 32'(pc), 32'h0);
    check("to_no_retire", 32'(retire_seen), 32'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("to_rst_err", 32'(bus_err), 32'h0);

    // Ready on the timeout cycle beats the error
    go_to_m(1'b1);
    dmem = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) tick();
    dmem = 1'b1; tick();
    check("late_ready_w", 32'(phase), 32'h10);
    check("late_ready_err", 32'(bus_err), 32'h0);
    tick();

    // Reset in the middle of a stalled M
    tick(); tick(); mem_op = 1'b1; tick(); mem_op = 1'b0;
    dmem = 1'b0; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0; dmem = 1'b1;
    check("midm_phase", 32'(phase), 32'h0);
    check("midm_pc", 32'(pc), 32'h0);
    check("midm_err", 32'(bus_err), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst    = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      start  = $urandom_range(0, 1) == 1;
      imem   = $urandom_range(0, 9) < 7;
      dmem   = $urandom_range(0, 9) < 6;
      mem_op = $urandom_range(0, 1) == 1;
      br     = $urandom_range(0, 3) == 0;
      tgt    = 16'($urandom);
      halt   = $urandom_range(0, 39) == 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
